// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [7:0]        dm_wdata;
    logic [7:0]        dm_rdata;
    logic              dm_done;
    logic              dm_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (IF) and load/store (DM).
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ack does not arrive within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 16
) (
    input logic                clk_i,
    input logic                reset_i,
    mem_port_arbiter_if.slave  arb_io
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy, done, tmo, starved, grant_if, grant_dm;

    assign busy     = state_q != IDLE;
    assign starved  = starve_q == SW'(STARVE_MAX);
    assign done     = (busy && arb_io.mem_ack) || tmo;
    assign grant_if = !busy && arb_io.if_req && (!arb_io.dm_req || starved);
    assign grant_dm = !busy && arb_io.dm_req && !grant_if;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) tmo_q <= '0;
        else         tmo_q <= (busy && !done) ? tmo_q + TW'(1) : '0;
    assign tmo = busy && !arb_io.mem_ack && tmo_q == TW'(TIMEOUT);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end

    // Memory command is captured at grant and held untouched until completion.
    always_comb begin
        state_d     = grant_if ? BUSY_IF : grant_dm ? BUSY_DM : done ? IDLE : state_q;
        mem_req_d   = (grant_if || grant_dm) ? 1'b1 : done ? 1'b0 : mem_req_q;
        mem_we_d    = grant_if ? 1'b0 : grant_dm ? arb_io.dm_we : mem_we_q;
        mem_addr_d  = grant_if ? arb_io.if_addr : grant_dm ? arb_io.dm_addr : mem_addr_q;
        mem_wdata_d = grant_if ? '0 : grant_dm ? {{(DATA_W-8){1'b0}}, arb_io.dm_wdata} : mem_wdata_q;
        starve_d    = grant_if ? '0 : (grant_dm && arb_io.if_req && !starved) ? starve_q + SW'(1) : starve_q;
    end

    always_comb begin
        arb_io.if_valid  = state_q == BUSY_IF && done;
        arb_io.dm_done   = state_q == BUSY_DM && done;
        arb_io.if_rdata  = (arb_io.if_valid && !tmo) ? arb_io.mem_rdata : '0;
        arb_io.dm_rdata  = (arb_io.dm_done && !tmo) ? arb_io.mem_rdata[7:0] : '0;
        arb_io.if_stall  = arb_io.if_req && !arb_io.if_valid;
        arb_io.dm_stall  = arb_io.dm_req && !arb_io.dm_done;
        arb_io.bus_err   = tmo;
        arb_io.mem_req   = mem_req_q;
        arb_io.mem_we    = mem_we_q;
        arb_io.mem_addr  = mem_addr_q;
        arb_io.mem_wdata = mem_wdata_q;
    end
endmodule
